// File: rtl/debounce_event_detect.sv
// Edge/event detector for a debounced level: qualified edge pulses, sticky interrupt,
// saturating event counter, stuck-level watchdog and a 4-phase clear handshake.
module debounce_event_detect #(
   parameter int CNT_W   = 8,
   parameter int STUCK_W = 10
) (
   input  logic               selected_db_clk,
   input  logic               rst_n,
   input  logic               INDEBOUNCEx,
   input  logic [1:0]         EDGESELx,
   input  logic [STUCK_W-1:0] STUCKLIMx,
   input  logic               clr_req,
   output logic               clr_ack,
   output logic               LEVELx,
   output logic               EVTPULSEx,
   output logic               INTx,
   output logic [CNT_W-1:0]   EVTCNTx,
   output logic               STUCKx
);

   typedef enum logic [1:0] {S_INIT, S_LOW, S_HIGH} state_t;

   state_t             state;
   logic [STUCK_W-1:0] stk_tmr;

   logic               rise_edge, fall_edge, qual_evt, clr_pulse, stuck_hit;
   logic [STUCK_W-1:0] stk_inc;
   logic [CNT_W-1:0]   cnt_inc;

   assign rise_edge = (state == S_LOW)  &  INDEBOUNCEx;
   assign fall_edge = (state == S_HIGH) & ~INDEBOUNCEx;
   assign qual_evt  = (rise_edge & EDGESELx[0]) | (fall_edge & EDGESELx[1]);
   // Clear fires once, on the edge where clr_ack rises.
   assign clr_pulse = clr_req & ~clr_ack;

   assign stk_inc = (&stk_tmr) ? stk_tmr : stk_tmr + STUCK_W'(1);
   assign cnt_inc = (&EVTCNTx) ? EVTCNTx : EVTCNTx + CNT_W'(1);

   // Threshold reached on an edge with no level change since the last transition/entry.
   assign stuck_hit = (STUCKLIMx != '0) && (state != S_INIT) &&
                      !rise_edge && !fall_edge && (stk_inc >= STUCKLIMx);

   always_ff @(posedge selected_db_clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_INIT;
         stk_tmr   <= '0;
         LEVELx    <= 1'b0;
         EVTPULSEx <= 1'b0;
         INTx      <= 1'b0;
         EVTCNTx   <= '0;
         STUCKx    <= 1'b0;
         clr_ack   <= 1'b0;
      end else begin
         clr_ack <= clr_req;

         case (state)
            S_INIT: begin
               LEVELx <= INDEBOUNCEx;
               state  <= INDEBOUNCEx ? S_HIGH : S_LOW;
            end
            S_LOW: if (INDEBOUNCEx) begin
               LEVELx <= 1'b1;
               state  <= S_HIGH;
            end
            S_HIGH: if (!INDEBOUNCEx) begin
               LEVELx <= 1'b0;
               state  <= S_LOW;
            end
            default: state <= S_INIT;
         endcase

         if (state == S_INIT || rise_edge || fall_edge || STUCKLIMx == '0)
            stk_tmr <= '0;
         else
            stk_tmr <= stk_inc;

         // A coinciding event or stuck detection wins over the clear.
         EVTPULSEx <= qual_evt;
         INTx      <= qual_evt | (INTx & ~clr_pulse);
         STUCKx    <= stuck_hit | (STUCKx & ~clr_pulse);
         if (clr_pulse)
            EVTCNTx <= qual_evt ? CNT_W'(1) : '0;
         else if (qual_evt)
            EVTCNTx <= cnt_inc;
      end
   end

endmodule

// File: tb/tb_debounce_event_detect.sv
// Directed self-checking bench for debounce_event_detect.
module tb_debounce_event_detect;

   localparam int CNT_W   = 8;
   localparam int STUCK_W = 10;

   logic               selected_db_clk = 1'b0;
   logic               rst_n;
   logic               INDEBOUNCEx;
   logic [1:0]         EDGESELx;
   logic [STUCK_W-1:0] STUCKLIMx;
   logic               clr_req;
   logic               clr_ack;
   logic               LEVELx;
   logic               EVTPULSEx;
   logic               INTx;
   logic [CNT_W-1:0]   EVTCNTx;
   logic               STUCKx;

   int checks   = 0;
   int failures = 0;

   debounce_event_detect #(.CNT_W(CNT_W), .STUCK_W(STUCK_W)) dut (
      .selected_db_clk (selected_db_clk),
      .rst_n           (rst_n),
      .INDEBOUNCEx     (INDEBOUNCEx),
      .EDGESELx        (EDGESELx),
      .STUCKLIMx       (STUCKLIMx),
      .clr_req         (clr_req),
      .clr_ack         (clr_ack),
      .LEVELx          (LEVELx),
      .EVTPULSEx       (EVTPULSEx),
      .INTx            (INTx),
      .EVTCNTx         (EVTCNTx),
      .STUCKx          (STUCKx)
   );

   always #5 selected_db_clk = ~selected_db_clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge selected_db_clk);
      #1;
   endtask

   int ack_cycles;
   int pulse_cnt;
   int stuck_seen;

   initial begin
      rst_n       = 1'b0;
      INDEBOUNCEx = 1'b1;
      EDGESELx    = 2'b11;
      STUCKLIMx   = '0;
      clr_req     = 1'b0;
      tick(); tick();
      chk("rst_level", LEVELx, 0);
      chk("rst_pulse", EVTPULSEx, 0);
      chk("rst_cnt",   EVTCNTx, 0);
      chk("rst_int_stuck_ack", {INTx, STUCKx, clr_ack}, 0);

      // Input already high at reset release: level loads, no event.
      rst_n = 1'b1;
      pulse_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         pulse_cnt += EVTPULSEx;
      end
      chk("init_level", LEVELx, 1);
      chk("init_no_pulse", pulse_cnt, 0);
      chk("init_cnt", EVTCNTx, 0);
      chk("init_int", INTx, 0);

      // Rising-only qualification.
      EDGESELx = 2'b01;
      INDEBOUNCEx = 1'b0; tick();
      chk("fall_unqual_pulse", EVTPULSEx, 0);
      chk("fall_level", LEVELx, 0);
      tick(); tick();
      INDEBOUNCEx = 1'b1; tick();
      chk("rise1_pulse", EVTPULSEx, 1);
      chk("rise1_cnt", EVTCNTx, 1);
      tick();
      chk("rise1_pulse_end", EVTPULSEx, 0);
      tick();
      INDEBOUNCEx = 1'b0; tick();
      chk("fall2_pulse", EVTPULSEx, 0);
      tick(); tick();
      INDEBOUNCEx = 1'b1; tick();
      chk("rise2_pulse", EVTPULSEx, 1);
      tick();
      chk("rise2_pulse_end", EVTPULSEx, 0);
      chk("rise_cnt", EVTCNTx, 2);
      chk("rise_int", INTx, 1);

      // Clear handshake.
      clr_req = 1'b1; tick();
      chk("clr_ack_hi", clr_ack, 1);
      chk("clr_cnt", EVTCNTx, 0);
      chk("clr_int", INTx, 0);
      clr_req = 1'b0; tick();
      chk("clr_ack_lo", clr_ack, 0);

      // Saturation over 260 both-edge events.
      EDGESELx = 2'b11;
      for (int i = 0; i < 260; i++) begin
         INDEBOUNCEx = ~INDEBOUNCEx;
         tick();
         if (i == 254) chk("sat_reach", EVTCNTx, 255);
      end
      chk("sat_hold", EVTCNTx, 255);
      clr_req = 1'b1; tick();
      clr_req = 1'b0; tick();

      // Stuck threshold 4.
      STUCKLIMx = 10'd4;
      INDEBOUNCEx = 1'b0; tick();
      tick(); tick(); tick();
      chk("stuck_3rd", STUCKx, 0);
      tick();
      chk("stuck_4th", STUCKx, 1);
      INDEBOUNCEx = 1'b1; tick();
      chk("stuck_sticky", STUCKx, 1);

      // Threshold 0 never sets.
      STUCKLIMx = '0;
      clr_req = 1'b1; tick();
      chk("stuck_clr", STUCKx, 0);
      clr_req = 1'b0; tick();
      stuck_seen = 0;
      for (int i = 0; i < 2000; i++) begin
         tick();
         stuck_seen |= STUCKx;
      end
      chk("stuck_dis", stuck_seen, 0);

      // Event coinciding with clear edge wins; single clear over a 5-cycle request.
      chk("pre_clr_cnt", EVTCNTx, 0);
      clr_req = 1'b1;
      INDEBOUNCEx = 1'b0;
      ack_cycles = 0;
      tick();
      chk("clrevt_cnt", EVTCNTx, 1);
      chk("clrevt_int", INTx, 1);
      ack_cycles += clr_ack;
      for (int i = 0; i < 4; i++) begin
         tick();
         ack_cycles += clr_ack;
      end
      clr_req = 1'b0; tick();
      ack_cycles += clr_ack;
      chk("clrevt_ack_cycles", ack_cycles, 5);
      chk("clrevt_single", EVTCNTx, 1);
      chk("clrevt_int_hold", INTx, 1);

      // Asynchronous reset mid-handshake with count 7.
      clr_req = 1'b1; tick();
      for (int i = 0; i < 7; i++) begin
         INDEBOUNCEx = ~INDEBOUNCEx;
         tick();
      end
      chk("pre_rst_cnt", EVTCNTx, 7);
      chk("pre_rst_ack", clr_ack, 1);
      #2;
      rst_n = 1'b0;
      INDEBOUNCEx = 1'b1;
      #1;
      chk("arst_cnt", EVTCNTx, 0);
      chk("arst_outs", {LEVELx, EVTPULSEx, INTx, STUCKx, clr_ack}, 0);
      tick();
      clr_req = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("rerst_level", LEVELx, 1);
      chk("rerst_pulse", EVTPULSEx, 0);
      chk("rerst_cnt", EVTCNTx, 0);
      INDEBOUNCEx = 1'b0; tick();
      chk("rerst_fsm_fall", EVTPULSEx, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
